mem_stage: RTL and testbench

Memory-access stage of the 5-stage RV32 pipeline, between execute and writeback. It latches execute results on me_i_ce and performs STORE/LOAD through an internal word-addressed data memory using a Wishbone-style cyc/stb/we handshake. It asserts stall while an access is outstanding. It forwards rd address, data and write-enable to writeback.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/data_mem.sv | 54 +++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcode constants, FSM state type and opcode decode helpers
// shared by the memory stage and its data memory.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

package mem_stage_pkg;

  localparam logic [`OPCODE_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [`OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
  localparam logic [`OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
  localparam logic [`OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
  localparam logic [`OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } mem_state_t;

  // Opcodes that retire in one cycle and write the register file.
  function automatic logic op_writes_rd(input logic [`OPCODE_WIDTH-1:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // Opcodes that need a data-memory bus cycle.
  function automatic logic op_is_mem(input logic [`OPCODE_WIDTH-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: Wishbone-style slave holding 2^AWIDTH x DWIDTH words.
// Read data is registered; ack marks the cycle in which the access commits.
// With MEM_STAGE_WAIT_STATE_EN defined, each access spends one wait cycle
// before ack is given.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [AWIDTH-1:0] adr,
  input  logic [DWIDTH-1:0] dat_i,
  output logic [DWIDTH-1:0] dat_o,
  output logic              ack
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic              req;

  assign req = cyc & stb;

`ifdef MEM_STAGE_WAIT_STATE_EN
  logic wait_done;

  // Wait-state tracker: the first strobed cycle only arms it, the second acks;
  // it restarts whenever the master drops the cycle.
  always_ff @(posedge clk) begin
    if (!rst)      wait_done <= 1'b0;
    else if (!cyc) wait_done <= 1'b0;
    else if (stb)  wait_done <= ~wait_done;
  end

  assign ack = req & wait_done;
`else
  assign ack = req;
`endif

  // Storage write on an acknowledged write cycle; contents are never reset.
  always_ff @(posedge clk) begin
    if (ack && we) mem[adr] <= dat_i;
  end

  // Registered read word, updated only by an acknowledged read.
  always_ff @(posedge clk) begin
    if (!rst)            dat_o <= '0;
    else if (ack && !we) dat_o <= mem[adr];
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32 pipeline. Latches execute
// results, runs STORE/LOAD through the internal data_mem with a cyc/stb/we
// handshake, stalls upstream while an access is outstanding and forwards
// rd address/data/write-enable to writeback.
// Optional build macro: MEM_STAGE_WAIT_STATE_EN (two-cycle memory access).
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                     me_clk,
  input  logic                     me_rst,
  input  logic                     me_i_ce,
  input  logic                     me_i_stall,
  input  logic                     me_i_flush,
  input  logic [DWIDTH-1:0]        me_i_rs2_data,
  input  logic [DWIDTH-1:0]        me_i_alu_value,
  input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [AWIDTH-1:0]        me_i_rd_addr,
  input  logic [DWIDTH-1:0]        me_i_rd_data,
  output logic                     me_o_ce,
  output logic                     me_o_stall,
  output logic                     me_o_flush,
  output logic [`OPCODE_WIDTH-1:0] me_o_opcode,
  output logic                     me_o_cyc,
  output logic                     me_o_stb,
  output logic                     me_o_we,
  output logic [AWIDTH-1:0]        me_o_store_addr,
  output logic [DWIDTH-1:0]        me_o_store_data,
  output logic [AWIDTH-1:0]        me_o_load_addr,
  output logic [DWIDTH-1:0]        me_o_load_data,
  output logic [AWIDTH-1:0]        me_o_rd_addr,
  output logic [DWIDTH-1:0]        me_o_rd_data,
  output logic                     me_o_rd_we
);

  mem_state_t               state_q, state_d;
  logic                     busy;
  logic                     accept;
  logic                     mem_stb;
  logic                     mem_ack;
  logic [AWIDTH-1:0]        addr_q;
  logic [DWIDTH-1:0]        rd_data_q;
  logic                     rd_sel_mem_q;
  logic [DWIDTH-AWIDTH-1:0] alu_high_unused;
  logic [FUNCT_WIDTH-1:0]   funct_unused;

  // Only the low address bits select a word; funct3 is reserved.
  assign alu_high_unused = me_i_alu_value[DWIDTH-1:AWIDTH];
  assign funct_unused    = '0;

  assign me_o_stall = me_i_stall | busy;
  assign me_o_flush = me_i_flush;
  assign accept     = me_i_ce & ~me_o_stall;

  // The memory only sees a live strobe when this edge is not reset, flushed
  // or held, so an abandoned access can never write.
  assign mem_stb = busy & me_rst & ~me_i_flush & ~me_i_stall;

  // FSM state register.
  always_ff @(posedge me_clk) begin
    if (!me_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: flush abandons, stall holds, ack completes.
  always_comb begin
    state_d = state_q;
    if (me_i_flush) begin
      state_d = ST_IDLE;
    end else if (!me_i_stall) begin
      case (state_q)
        ST_IDLE:   if (accept && op_is_mem(me_i_opcode)) state_d = ST_ACCESS;
        ST_ACCESS: if (mem_ack)                          state_d = ST_IDLE;
        default:                                         state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: bus signals follow the registered state.
  always_comb begin
    busy     = (state_q == ST_ACCESS);
    me_o_cyc = busy;
    me_o_stb = busy;
    me_o_we  = busy && (me_o_opcode == OP_STORE);
  end

  // Pipeline registers: accept latches the instruction, ack retires memory ops.
  always_ff @(posedge me_clk) begin
    if (!me_rst) begin
      me_o_ce         <= 1'b0;
      me_o_rd_we      <= 1'b0;
      me_o_opcode     <= '0;
      me_o_rd_addr    <= '0;
      me_o_store_addr <= '0;
      me_o_store_data <= '0;
      me_o_load_addr  <= '0;
      addr_q          <= '0;
      rd_data_q       <= '0;
      rd_sel_mem_q    <= 1'b0;
    end else if (me_i_flush) begin
      me_o_ce    <= 1'b0;
      me_o_rd_we <= 1'b0;
    end else if (!me_i_stall) begin
      if (mem_ack) begin
        me_o_ce    <= 1'b1;
        me_o_rd_we <= (me_o_opcode == OP_LOAD);
        if (me_o_opcode == OP_LOAD) rd_sel_mem_q <= 1'b1;
      end else if (accept) begin
        me_o_opcode  <= me_i_opcode;
        me_o_rd_addr <= me_i_rd_addr;
        addr_q       <= me_i_alu_value[AWIDTH-1:0];
        if (op_is_mem(me_i_opcode)) begin
          me_o_ce    <= 1'b0;
          me_o_rd_we <= 1'b0;
          if (me_i_opcode == OP_STORE) begin
            me_o_store_addr <= me_i_alu_value[AWIDTH-1:0];
            me_o_store_data <= me_i_rs2_data;
          end else begin
            me_o_load_addr <= me_i_alu_value[AWIDTH-1:0];
          end
        end else begin
          me_o_ce      <= 1'b1;
          me_o_rd_we   <= op_writes_rd(me_i_opcode);
          rd_data_q    <= me_i_rd_data;
          rd_sel_mem_q <= 1'b0;
        end
      end else begin
        me_o_ce    <= 1'b0;
        me_o_rd_we <= 1'b0;
      end
    end
  end

  // After a load, rd data comes straight from the memory's registered word.
  always_comb begin
    me_o_rd_data = rd_sel_mem_q ? me_o_load_data : rd_data_q;
  end

  data_mem #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_data_mem (
    .clk   (me_clk),
    .rst   (me_rst),
    .cyc   (busy),
    .stb   (mem_stb),
    .we    (me_o_we),
    .adr   (addr_q),
    .dat_i (me_o_store_data),
    .dat_o (me_o_load_data),
    .ack   (mem_ack)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage plus hand-written
// sequences for the memory-access corner cases.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef MEM_STAGE_WAIT_STATE_EN
  localparam int WAIT_CYCLES = 1;
`else
  localparam int WAIT_CYCLES = 0;
`endif

  logic                     me_clk = 1'b0;
  logic                     me_rst;
  logic                     me_i_ce, me_i_stall, me_i_flush;
  logic [DW-1:0]            me_i_rs2_data, me_i_alu_value, me_i_rd_data;
  logic [`OPCODE_WIDTH-1:0] me_i_opcode;
  logic [AW-1:0]            me_i_rd_addr;
  logic                     me_o_ce, me_o_stall, me_o_flush;
  logic [`OPCODE_WIDTH-1:0] me_o_opcode;
  logic                     me_o_cyc, me_o_stb, me_o_we;
  logic [AW-1:0]            me_o_store_addr, me_o_load_addr, me_o_rd_addr;
  logic [DW-1:0]            me_o_store_data, me_o_load_data, me_o_rd_data;
  logic                     me_o_rd_we;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic                     ce;
    logic                     stall;
    logic                     flush;
    logic [`OPCODE_WIDTH-1:0] op;
    logic [AW-1:0]            rd;
    logic [DW-1:0]            rdData;
    logic                     expCe;
    logic                     expWe;
    logic [AW-1:0]            expRd;
    logic [DW-1:0]            expData;
    logic                     expStall;
    logic                     expFlush;
  } vec_t;

  vec_t vecs[10];

  mem_stage #(.AWIDTH(AW), .DWIDTH(DW), .FUNCT_WIDTH(3)) dut (
    .me_clk          (me_clk),
    .me_rst          (me_rst),
    .me_i_ce         (me_i_ce),
    .me_i_stall      (me_i_stall),
    .me_i_flush      (me_i_flush),
    .me_i_rs2_data   (me_i_rs2_data),
    .me_i_alu_value  (me_i_alu_value),
    .me_i_opcode     (me_i_opcode),
    .me_i_rd_addr    (me_i_rd_addr),
    .me_i_rd_data    (me_i_rd_data),
    .me_o_ce         (me_o_ce),
    .me_o_stall      (me_o_stall),
    .me_o_flush      (me_o_flush),
    .me_o_opcode     (me_o_opcode),
    .me_o_cyc        (me_o_cyc),
    .me_o_stb        (me_o_stb),
    .me_o_we         (me_o_we),
    .me_o_store_addr (me_o_store_addr),
    .me_o_store_data (me_o_store_data),
    .me_o_load_addr  (me_o_load_addr),
    .me_o_load_data  (me_o_load_data),
    .me_o_rd_addr    (me_o_rd_addr),
    .me_o_rd_data    (me_o_rd_data),
    .me_o_rd_we      (me_o_rd_we)
  );

  // Free-running clock.
  always #5 me_clk = ~me_clk;

  // Drive all inputs; called just after a falling edge.
  task automatic applyStimulus(input logic ce, input logic stall, input logic flush,
                               input logic [`OPCODE_WIDTH-1:0] op, input logic [DW-1:0] alu,
                               input logic [DW-1:0] rs2, input logic [AW-1:0] rd,
                               input logic [DW-1:0] rdData);
    me_i_ce        = ce;
    me_i_stall     = stall;
    me_i_flush     = flush;
    me_i_opcode    = op;
    me_i_alu_value = alu;
    me_i_rs2_data  = rs2;
    me_i_rd_addr   = rd;
    me_i_rd_data   = rdData;
  endtask

  // One rising edge, then return at the following falling edge for sampling.
  task automatic stepCycle();
    @(posedge me_clk);
    @(negedge me_clk);
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Extra busy cycle(s) when the memory inserts a wait state.
  task automatic waitStates(input string name);
    for (int w = 0; w < WAIT_CYCLES; w++) begin
      stepCycle();
      checkOutput({name, " wait stall"}, 32'(me_o_stall), 32'd1);
      checkOutput({name, " wait ce"}, 32'(me_o_ce), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, OP_RTYPE,  5'd3,  32'd12345,    1'b1, 1'b1, 5'd3,  32'd12345,    1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, OP_RTYPE,  5'd20, 32'd1,        1'b0, 1'b0, 5'd3,  32'd12345,    1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, OP_ITYPE,  5'd5,  32'h000000AA, 1'b1, 1'b1, 5'd5,  32'h000000AA, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, OP_LUI,    5'd6,  32'h12340000, 1'b1, 1'b1, 5'd6,  32'h12340000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, OP_AUIPC,  5'd7,  32'h00000100, 1'b1, 1'b1, 5'd7,  32'h00000100, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, OP_JAL,    5'd1,  32'h00000044, 1'b1, 1'b1, 5'd1,  32'h00000044, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, OP_JALR,   5'd2,  32'h00000048, 1'b1, 1'b1, 5'd2,  32'h00000048, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, OP_BRANCH, 5'd9,  32'h00000077, 1'b1, 1'b0, 5'd9,  32'h00000077, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 7'h7F,     5'd10, 32'h00000055, 1'b1, 1'b0, 5'd10, 32'h00000055, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b1, OP_RTYPE,  5'd11, 32'h00000066, 1'b0, 1'b0, 5'd10, 32'h00000055, 1'b0, 1'b1};

    // Reset held low for two edges.
    me_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    stepCycle();
    stepCycle();
    checkOutput("reset ce", 32'(me_o_ce), 32'd0);
    checkOutput("reset rd_we", 32'(me_o_rd_we), 32'd0);
    checkOutput("reset stall", 32'(me_o_stall), 32'd0);
    checkOutput("reset cyc", 32'(me_o_cyc), 32'd0);
    checkOutput("reset stb", 32'(me_o_stb), 32'd0);
    checkOutput("reset we", 32'(me_o_we), 32'd0);
    checkOutput("reset opcode", 32'(me_o_opcode), 32'd0);
    checkOutput("reset rd_addr", 32'(me_o_rd_addr), 32'd0);
    checkOutput("reset rd_data", me_o_rd_data, 32'd0);
    checkOutput("reset load_data", me_o_load_data, 32'd0);
    checkOutput("reset store_data", me_o_store_data, 32'd0);
    me_rst = 1'b1;

    // Single-cycle opcodes from the vector table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ce, vecs[i].stall, vecs[i].flush, vecs[i].op, 32'd0, 32'd0,
                    vecs[i].rd, vecs[i].rdData);
      stepCycle();
      checkOutput($sformatf("vec%0d ce", i), 32'(me_o_ce), 32'(vecs[i].expCe));
      checkOutput($sformatf("vec%0d rd_we", i), 32'(me_o_rd_we), 32'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d rd_addr", i), 32'(me_o_rd_addr), 32'(vecs[i].expRd));
      checkOutput($sformatf("vec%0d rd_data", i), me_o_rd_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d stall", i), 32'(me_o_stall), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d flush", i), 32'(me_o_flush), 32'(vecs[i].expFlush));
    end

    // Downstream stall holds the previous result until it clears.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_RTYPE, 32'd0, 32'd0, 5'd3, 32'd12345);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, OP_RTYPE, 32'd0, 32'd0, 5'd4, 32'h0000BEEF);
    stepCycle();
    checkOutput("stall hold rd_addr", 32'(me_o_rd_addr), 32'd3);
    checkOutput("stall hold rd_data", me_o_rd_data, 32'd12345);
    checkOutput("stall hold ce", 32'(me_o_ce), 32'd1);
    checkOutput("stall out", 32'(me_o_stall), 32'd1);
    me_i_stall = 1'b0;
    stepCycle();
    checkOutput("stall release rd_addr", 32'(me_o_rd_addr), 32'd4);
    checkOutput("stall release rd_data", me_o_rd_data, 32'h0000BEEF);
    checkOutput("stall release rd_we", 32'(me_o_rd_we), 32'd1);

    // STORE addr 10, data 14.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_STORE, 32'd10, 32'd14, 5'd0, 32'd0);
    stepCycle();
    me_i_ce = 1'b0;
    checkOutput("store cyc", 32'(me_o_cyc), 32'd1);
    checkOutput("store stb", 32'(me_o_stb), 32'd1);
    checkOutput("store we", 32'(me_o_we), 32'd1);
    checkOutput("store addr", 32'(me_o_store_addr), 32'd10);
    checkOutput("store data", me_o_store_data, 32'd14);
    checkOutput("store stall", 32'(me_o_stall), 32'd1);
    checkOutput("store busy ce", 32'(me_o_ce), 32'd0);
    waitStates("store");
    stepCycle();
    checkOutput("store done stall", 32'(me_o_stall), 32'd0);
    checkOutput("store done ce", 32'(me_o_ce), 32'd1);
    checkOutput("store done rd_we", 32'(me_o_rd_we), 32'd0);
    checkOutput("store done cyc", 32'(me_o_cyc), 32'd0);

    // LOAD addr 10 into rd 8.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_LOAD, 32'd10, 32'd0, 5'd8, 32'd0);
    stepCycle();
    me_i_ce = 1'b0;
    checkOutput("load cyc", 32'(me_o_cyc), 32'd1);
    checkOutput("load we", 32'(me_o_we), 32'd0);
    checkOutput("load addr", 32'(me_o_load_addr), 32'd10);
    waitStates("load");
    stepCycle();
    checkOutput("load data", me_o_load_data, 32'd14);
    checkOutput("load rd_data", me_o_rd_data, 32'd14);
    checkOutput("load rd_addr", 32'(me_o_rd_addr), 32'd8);
    checkOutput("load rd_we", 32'(me_o_rd_we), 32'd1);
    checkOutput("load ce", 32'(me_o_ce), 32'd1);
    stepCycle();
    checkOutput("load idle ce", 32'(me_o_ce), 32'd0);
    checkOutput("load idle rd_we", 32'(me_o_rd_we), 32'd0);
    checkOutput("load idle rd_data", me_o_rd_data, 32'd14);

    // ce while busy is ignored, then taken once stall drops.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_LOAD, 32'd10, 32'd0, 5'd11, 32'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, OP_RTYPE, 32'd0, 32'd0, 5'd12, 32'h00000999);
    waitStates("busy");
    stepCycle();
    checkOutput("busy ignore rd_addr", 32'(me_o_rd_addr), 32'd11);
    checkOutput("busy ignore rd_data", me_o_rd_data, 32'd14);
    stepCycle();
    me_i_ce = 1'b0;
    checkOutput("busy after rd_addr", 32'(me_o_rd_addr), 32'd12);
    checkOutput("busy after rd_data", me_o_rd_data, 32'h00000999);

    // Flush during ACCESS abandons the store.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_STORE, 32'd10, 32'd99, 5'd0, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, OP_STORE, 32'd10, 32'd99, 5'd0, 32'd0);
    stepCycle();
    checkOutput("flush cyc", 32'(me_o_cyc), 32'd0);
    checkOutput("flush stall", 32'(me_o_stall), 32'd0);
    checkOutput("flush ce", 32'(me_o_ce), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, OP_LOAD, 32'd10, 32'd0, 5'd13, 32'd0);
    stepCycle();
    me_i_ce = 1'b0;
    waitStates("flush reload");
    stepCycle();
    checkOutput("flush reload data", me_o_rd_data, 32'd14);

    // Address 37 wraps to 5.
    applyStimulus(1'b1, 1'b0, 1'b0, OP_STORE, 32'd37, 32'h00005A5A, 5'd0, 32'd0);
    stepCycle();
    me_i_ce = 1'b0;
    checkOutput("wrap store addr", 32'(me_o_store_addr), 32'd5);
    waitStates("wrap store");
    stepCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, OP_LOAD, 32'd5, 32'd0, 5'd14, 32'd0);
    stepCycle();
    me_i_ce = 1'b0;
    waitStates("wrap load");
    stepCycle();
    checkOutput("wrap load data", me_o_rd_data, 32'h00005A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
